// File: rtl/front_end_pkg.sv
// Shared types and defaults for the coprocessor control front end.
// State encoding is fixed so the register front end can decode it.
package front_end_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_N_CH  = 2;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_LAT   = 3;

endpackage

// File: rtl/valid_pipe.sv
// Enable-gated valid delay line matching the datapath latency.
// Only the oldest stage is exposed; it marks a result leaving the datapath.
module valid_pipe #(
  parameter int LAT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic din,
  output logic dout
);

  logic [LAT-1:0] q;

  generate
    if (LAT == 1) begin : g_one
      always_ff @(posedge clk) begin
        if (rst)
          q <= '0;
        else if (en)
          q <= din;
      end
    end else begin : g_many
      always_ff @(posedge clk) begin
        if (rst)
          q <= '0;
        else if (en)
          q <= {q[LAT-2:0], din};
      end
    end
  endgenerate

  assign dout = q[LAT-1];

endmodule

// File: rtl/front_end_pipe.sv
// Control front end: lockstep channel reads, datapath enable gating,
// in-flight tracking and completion after a programmed word count.
module front_end_pipe
  import front_end_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int LAT   = DEF_LAT
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [N_CH-1:0]  empty,
  input  logic             full,
  output logic             en,
  output logic [N_CH-1:0]  rden,
  output logic             wr,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] wr_cnt;
  logic             adv;
  logic             issue;
  logic             in_run;
  logic             in_drain;
  logic             vlast;

  assign adv      = !full;
  assign in_run   = (state == RUN);
  assign in_drain = (state == DRAIN);
  assign issue    = in_run && adv && !(|empty)
                 && (rd_cnt != len_q);

  assign en   = (in_run || in_drain) && adv;
  assign rden = {N_CH{issue}};
  assign wr   = en && vlast;
  assign busy = in_run || in_drain;
  assign done = (state == DONE);

  // Bubbles enter on empty stalls; full freezes the line.
  valid_pipe #(
    .LAT (LAT)
  ) u_vpipe (
    .clk  (aclk),
    .rst  (areset),
    .en   (en),
    .din  (issue),
    .dout (vlast)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state  <= IDLE;
      len_q  <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              state  <= RUN;
              len_q  <= len;
              rd_cnt <= '0;
              wr_cnt <= '0;
            end else begin
              state <= DONE;
            end
          end
        end
        RUN: begin
          if (issue)
            rd_cnt <= rd_cnt + ONE;
          if (wr)
            wr_cnt <= wr_cnt + ONE;
          if (issue && rd_cnt == len_q - ONE)
            state <= DRAIN;
        end
        DRAIN: begin
          if (wr) begin
            wr_cnt <= wr_cnt + ONE;
            if (wr_cnt == len_q - ONE)
              state <= DONE;
          end
        end
        DONE: begin
          if (!start)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_front_end_pipe.sv
// Randomized and directed bench for front_end_pipe against a
// timestamp-queue reference model.
module tb_front_end_pipe;

  localparam int LAT = 3;

  logic        aclk = 1'b0;
  logic        areset;
  logic        start;
  logic [15:0] len;
  logic [1:0]  empty;
  logic        full;
  logic        en;
  logic [1:0]  rden;
  logic        wr;
  logic        busy;
  logic        done;

  logic        start4;
  logic [3:0]  len4;
  logic        en4;
  logic [1:0]  rden4;
  logic        wr4;
  logic        busy4;
  logic        done4;

  always #5 aclk = ~aclk;

  front_end_pipe #(.N_CH(2), .CNT_W(16), .LAT(LAT)) dut (
    .aclk(aclk), .areset(areset), .start(start), .len(len),
    .empty(empty), .full(full), .en(en), .rden(rden),
    .wr(wr), .busy(busy), .done(done)
  );

  front_end_pipe #(.N_CH(2), .CNT_W(4), .LAT(LAT)) dut4 (
    .aclk(aclk), .areset(areset), .start(start4), .len(len4),
    .empty(empty), .full(full), .en(en4), .rden(rden4),
    .wr(wr4), .busy(busy4), .done(done4)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: phase plus a queue of enabled-cycle due times.
  int   mph = 0;
  int   m_len = 0;
  int   m_iss = 0;
  int   m_wrn = 0;
  int   ecnt = 0;
  int   dueq[$];
  logic m_en, m_issue, m_wr;
  logic [5:0] expv;
  logic [5:0] obs;

  assign obs = {en, rden, wr, busy, done};

  int rd_n, wr_n, en_n;
  int first_rd, first_wr, last_rd, last_wr, done_cyc;
  logic rd_hist[0:63];

  task automatic model_eval();
    logic act;
    act     = (mph == 1) || (mph == 2);
    m_en    = act && !full;
    m_issue = (mph == 1) && !full && (empty == 2'b00)
           && (m_iss < m_len);
    m_wr    = m_en && (dueq.size() > 0) && (dueq[0] == ecnt);
    expv    = {m_en, {2{m_issue}}, m_wr, act, (mph == 3)};
  endtask

  task automatic model_clock();
    if (areset) begin
      mph = 0;
      m_iss = 0;
      m_wrn = 0;
      ecnt = 0;
      dueq.delete();
    end else begin
      if (m_en) begin
        if (m_wr) begin
          void'(dueq.pop_front());
          m_wrn++;
        end
        if (m_issue) begin
          dueq.push_back(ecnt + LAT);
          m_iss++;
        end
        ecnt++;
      end
      case (mph)
        0: if (start) begin
          if (len != 0) begin
            mph = 1;
            m_len = int'(len);
            m_iss = 0;
            m_wrn = 0;
          end else begin
            mph = 3;
          end
        end
        1: if (m_issue && m_iss == m_len) mph = 2;
        2: if (m_wr && m_wrn == m_len) mph = 3;
        default: if (!start) mph = 0;
      endcase
    end
  endtask

  task automatic drive(input logic s, input int l, input logic f,
                       input logic [1:0] e, input logic r);
    start  = s;
    len    = 16'(l);
    full   = f;
    empty  = e;
    areset = r;
    #1;
    model_eval();
  endtask

  task automatic adv_clk();
    @(posedge aclk);
    model_clock();
    @(negedge aclk);
  endtask

  task automatic clr_tally();
    rd_n = 0; wr_n = 0; en_n = 0;
    first_rd = -1; first_wr = -1;
    last_rd = -1; last_wr = -1; done_cyc = -1;
    for (int i = 0; i < 64; i++) rd_hist[i] = 1'b0;
  endtask

  task automatic tally(input int c);
    if (en) en_n++;
    if (rden[0]) begin
      rd_n++;
      last_rd = c;
      if (first_rd < 0) first_rd = c;
      if (c < 64) rd_hist[c] = 1'b1;
    end
    if (wr) begin
      wr_n++;
      last_wr = c;
      if (first_wr < 0) first_wr = c;
    end
    if (done && done_cyc < 0) done_cyc = c;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 2'b00, 1);
    adv_clk();
    drive(0, 0, 0, 2'b00, 1);
    checks++;
    if (obs !== 6'b0) begin
      failures++;
      $display("FAIL reset_hold got=%b exp=%b", obs, 6'b0);
    end
    adv_clk();
    drive(0, 0, 0, 2'b00, 0);
    checks++;
    if (obs !== expv || obs !== 6'b0) begin
      failures++;
      $display("FAIL reset_rel got=%b exp=%b", obs, expv);
    end
    adv_clk();
  endtask

  task automatic test_basic();
    clr_tally();
    for (int c = 0; c < 12; c++) begin
      drive(1, 4, 0, 2'b00, 0);
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL basic c=%0d got=%b exp=%b", c, obs, expv);
      end
      tally(c);
      adv_clk();
    end
    checks++;
    if (rd_n !== 4 || wr_n !== 4) begin
      failures++;
      $display("FAIL basic_cnt got=%0d/%0d exp=4/4", rd_n, wr_n);
    end
    checks++;
    if (first_rd !== 1 || first_wr - first_rd !== 3) begin
      failures++;
      $display("FAIL basic_lat got=%0d,%0d exp=1,4",
               first_rd, first_wr);
    end
    checks++;
    if (done_cyc !== last_wr + 1) begin
      failures++;
      $display("FAIL basic_done got=%0d exp=%0d",
               done_cyc, last_wr + 1);
    end
    for (int c = 0; c < 2; c++) begin
      drive(0, 4, 0, 2'b00, 0);
      checks++;
      if (obs !== expv || (c == 1 && obs !== 6'b0)) begin
        failures++;
        $display("FAIL basic_idle c=%0d got=%b exp=%b",
                 c, obs, expv);
      end
      adv_clk();
    end
  endtask

  task automatic test_backpressure();
    logic f;
    clr_tally();
    for (int c = 0; c < 20; c++) begin
      f = (c == 3) || (c == 4);
      drive(1, 6, f, 2'b00, 0);
      checks++;
      if (obs !== expv || (f && {en, rden, wr} !== 4'b0)) begin
        failures++;
        $display("FAIL bp c=%0d got=%b exp=%b", c, obs, expv);
      end
      tally(c);
      adv_clk();
    end
    checks++;
    if (rd_n !== 6 || wr_n !== 6 || done_cyc !== last_wr + 1) begin
      failures++;
      $display("FAIL bp_cnt got=%0d/%0d/%0d exp=6/6/%0d",
               rd_n, wr_n, done_cyc, last_wr + 1);
    end
    for (int c = 0; c < 2; c++) begin
      drive(0, 0, 0, 2'b00, 0);
      adv_clk();
    end
    model_eval();
  endtask

  task automatic test_underflow();
    logic [1:0] e;
    logic gap_ok;
    clr_tally();
    gap_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      e = (c >= 2 && c <= 4) ? 2'b10 : 2'b00;
      drive(1, 5, 0, e, 0);
      checks++;
      if (obs !== expv || (e != 0 && {en, rden} !== 3'b100)) begin
        failures++;
        $display("FAIL uf c=%0d got=%b exp=%b", c, obs, expv);
      end
      tally(c);
      if (c >= LAT && wr !== rd_hist[c-LAT]) gap_ok = 1'b0;
      adv_clk();
    end
    checks++;
    if (rd_n !== 5 || wr_n !== 5 || !gap_ok) begin
      failures++;
      $display("FAIL uf_cnt got=%0d/%0d/%b exp=5/5/1",
               rd_n, wr_n, gap_ok);
    end
    for (int c = 0; c < 2; c++) begin
      drive(0, 0, 0, 2'b00, 0);
      adv_clk();
    end
  endtask

  task automatic test_zero();
    clr_tally();
    for (int c = 0; c < 5; c++) begin
      drive(c < 3, 0, 0, 2'b00, 0);
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL zero c=%0d got=%b exp=%b", c, obs, expv);
      end
      tally(c);
      adv_clk();
    end
    checks++;
    if (done_cyc !== 1 || rd_n + wr_n + en_n !== 0) begin
      failures++;
      $display("FAIL zero_res got=%0d/%0d exp=1/0",
               done_cyc, rd_n + wr_n + en_n);
    end
  endtask

  task automatic test_reset_drain();
    clr_tally();
    for (int c = 0; c < 11; c++) begin
      drive(c < 6, (c < 6) ? 4 : 1, 0, 2'b00, c == 5);
      checks++;
      if (obs !== expv || (c >= 6 && obs !== 6'b0)) begin
        failures++;
        $display("FAIL rst_drain c=%0d got=%b exp=%b",
                 c, obs, expv);
      end
      if (c >= 6) tally(c);
      adv_clk();
    end
    checks++;
    if (wr_n !== 0) begin
      failures++;
      $display("FAIL rst_drain_wr got=%0d exp=0", wr_n);
    end
    clr_tally();
    for (int c = 0; c < 8; c++) begin
      drive(1, 1, 0, 2'b00, 0);
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL rst_len1 c=%0d got=%b exp=%b",
                 c, obs, expv);
      end
      tally(c);
      adv_clk();
    end
    checks++;
    if (rd_n !== 1 || wr_n !== 1 || done_cyc !== 5) begin
      failures++;
      $display("FAIL rst_len1_res got=%0d/%0d/%0d exp=1/1/5",
               rd_n, wr_n, done_cyc);
    end
    for (int c = 0; c < 2; c++) begin
      drive(0, 0, 0, 2'b00, 0);
      adv_clk();
    end
  endtask

  task automatic test_last_full();
    clr_tally();
    for (int c = 0; c < 12; c++) begin
      drive(1, 3, c == 3, 2'b00, 0);
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL lastfull c=%0d got=%b exp=%b",
                 c, obs, expv);
      end
      tally(c);
      adv_clk();
    end
    checks++;
    if (last_rd !== 4 || rd_n !== 3 || done_cyc !== 8) begin
      failures++;
      $display("FAIL lastfull_res got=%0d/%0d/%0d exp=4/3/8",
               last_rd, rd_n, done_cyc);
    end
    for (int c = 0; c < 2; c++) begin
      drive(0, 0, 0, 2'b00, 0);
      adv_clk();
    end
  endtask

  task automatic test_random();
    int l;
    logic f;
    logic [1:0] e;
    for (int run = 0; run < 8; run++) begin
      clr_tally();
      l = $urandom_range(1, 10);
      for (int c = 0; c < 200 && done_cyc < 0; c++) begin
        f = ($urandom_range(0, 3) == 0);
        e = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
        drive(1, l, f, e, 0);
        checks++;
        if (obs !== expv) begin
          failures++;
          $display("FAIL rand r=%0d c=%0d got=%b exp=%b",
                   run, c, obs, expv);
        end
        tally(c);
        adv_clk();
      end
      checks++;
      if (done_cyc < 0 || rd_n !== l || wr_n !== l) begin
        failures++;
        $display("FAIL rand_res r=%0d got=%0d/%0d/%0d exp=%0d",
                 run, rd_n, wr_n, done_cyc, l);
      end
      for (int c = 0; c < 2; c++) begin
        drive(0, 0, 0, 2'b00, 0);
        adv_clk();
      end
    end
  endtask

  task automatic test_max();
    int r4, w4, lw, dc;
    r4 = 0; w4 = 0; lw = -1; dc = -1;
    len4 = 4'd15;
    for (int c = 0; c < 30; c++) begin
      start4 = 1'b1;
      drive(0, 0, 0, 2'b00, 0);
      if (rden4[0]) r4++;
      if (wr4) begin
        w4++;
        lw = c;
      end
      if (done4 && dc < 0) dc = c;
      adv_clk();
    end
    checks++;
    if (r4 !== 15 || w4 !== 15 || dc !== lw + 1) begin
      failures++;
      $display("FAIL max_len got=%0d/%0d/%0d exp=15/15/%0d",
               r4, w4, dc, lw + 1);
    end
    start4 = 1'b0;
    adv_clk();
    adv_clk();
    checks++;
    if ({busy4, done4} !== 2'b00) begin
      failures++;
      $display("FAIL max_idle got=%b exp=00", {busy4, done4});
    end
  endtask

  initial begin
    start4 = 1'b0;
    len4   = 4'd0;
    @(negedge aclk);
    test_reset();
    test_basic();
    test_backpressure();
    test_underflow();
    test_zero();
    test_reset_drain();
    test_last_full();
    test_random();
    test_max();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
